// File: rtl/hazard_scheduler_pkg.sv
// Shared types and constants for the hazard scheduler and its random source.
package hazard_scheduler_pkg;

  localparam int          NUM_BOXES = 9;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PICK = 3'd1,
    ST_WARN = 3'd2,
    ST_FIRE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/hazard_scheduler_lfsr16.sv
// 16-bit Galois LFSR; free-running random source shared by random-event blocks.
module lfsr16
  import hazard_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  // LFSR state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard round sequencer: PICK -> WARN -> FIRE -> GAP, repeating while the game is active.
// Optional gold-box spawning is enabled by defining GOLD_SPAWN_EN.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          WARN_TICKS = 4,
  parameter int          FIRE_TICKS = 3,
  parameter int          GAP_TICKS  = 2,
  parameter int          MAX_FIRES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       game_active,
  input  logic [1:0] level,
  output logic [8:0] warning_state,
  output logic [8:0] fire_state,
  output logic [8:0] gold_state,
  output logic       round_done
);

`ifdef GOLD_SPAWN_EN
  localparam logic GOLD_EN = 1'b1;
`else
  localparam logic GOLD_EN = 1'b0;
`endif

  localparam logic [7:0] WARN_LEN = 8'(WARN_TICKS);
  localparam logic [7:0] FIRE_LEN = 8'(FIRE_TICKS);
  localparam logic [7:0] GAP_LEN  = 8'(GAP_TICKS);
  localparam logic [3:0] MAX_F    = 4'(MAX_FIRES);

  state_t      state_r;
  logic [15:0] lfsr_s;
  logic [8:0]  mask_r;
  logic [8:0]  gold_r;
  logic        gold_found_r;
  logic [3:0]  count_r;
  logic [3:0]  target_r;
  logic [7:0]  tick_cnt_r;
  logic [7:0]  warn_len_r;

  logic [3:0]  idx_s;
  logic [8:0]  bit_s;
  logic        cand_ok_s;
  logic [3:0]  target_s;
  logic [7:0]  warn_len_s;
  logic [7:0]  len_s;
  logic        tick_done_s;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .state (lfsr_s)
  );

  // Candidate selection, level-derived round parameters and phase-end detection
  always_comb begin
    idx_s     = lfsr_s[3:0];
    bit_s     = 9'd1 << idx_s;
    cand_ok_s = (idx_s < 4'd9) && ((mask_r & bit_s) == 9'd0);
    target_s  = {2'b00, level} + 4'd1;
    if (target_s > MAX_F) begin
      target_s = MAX_F;
    end else begin
      target_s = target_s;
    end
    if (WARN_LEN > {6'd0, level}) begin
      warn_len_s = WARN_LEN - {6'd0, level};
    end else begin
      warn_len_s = 8'd1;
    end
    case (state_r)
      ST_WARN: len_s = warn_len_r;
      ST_FIRE: len_s = FIRE_LEN;
      ST_GAP:  len_s = GAP_LEN;
      default: len_s = 8'd1;
    endcase
    tick_done_s = tick && ((tick_cnt_r + 8'd1) == len_s);
  end

  // Round sequencer with registered mask outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      mask_r        <= 9'd0;
      gold_r        <= 9'd0;
      gold_found_r  <= 1'b0;
      count_r       <= 4'd0;
      target_r      <= 4'd0;
      tick_cnt_r    <= 8'd0;
      warn_len_r    <= 8'd0;
      warning_state <= 9'd0;
      fire_state    <= 9'd0;
      gold_state    <= 9'd0;
      round_done    <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (!game_active) begin
        state_r       <= ST_IDLE;
        mask_r        <= 9'd0;
        gold_r        <= 9'd0;
        gold_found_r  <= 1'b0;
        count_r       <= 4'd0;
        tick_cnt_r    <= 8'd0;
        warning_state <= 9'd0;
        fire_state    <= 9'd0;
        gold_state    <= 9'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              state_r      <= ST_PICK;
              mask_r       <= 9'd0;
              gold_r       <= 9'd0;
              gold_found_r <= 1'b0;
              count_r      <= 4'd0;
              target_r     <= target_s;
            end
          end
          ST_PICK: begin
            if (count_r != target_r) begin
              if (cand_ok_s) begin
                mask_r  <= mask_r | bit_s;
                count_r <= count_r + 4'd1;
              end
            end else if (GOLD_EN && !gold_found_r) begin
              // candidate check already excludes boxes in the fire mask
              if (cand_ok_s) begin
                gold_r       <= bit_s;
                gold_found_r <= 1'b1;
              end
            end else begin
              state_r       <= ST_WARN;
              tick_cnt_r    <= 8'd0;
              warn_len_r    <= warn_len_s;
              warning_state <= mask_r;
              fire_state    <= 9'd0;
              gold_state    <= gold_r;
            end
          end
          ST_WARN: begin
            if (tick_done_s) begin
              state_r       <= ST_FIRE;
              tick_cnt_r    <= 8'd0;
              warning_state <= 9'd0;
              fire_state    <= mask_r;
            end else if (tick) begin
              tick_cnt_r <= tick_cnt_r + 8'd1;
            end
          end
          ST_FIRE: begin
            if (tick_done_s) begin
              state_r    <= ST_GAP;
              tick_cnt_r <= 8'd0;
              fire_state <= 9'd0;
              gold_state <= 9'd0;
              round_done <= 1'b1;
            end else if (tick) begin
              tick_cnt_r <= tick_cnt_r + 8'd1;
            end
          end
          ST_GAP: begin
            if (tick_done_s) begin
              state_r      <= ST_PICK;
              tick_cnt_r   <= 8'd0;
              mask_r       <= 9'd0;
              gold_r       <= 9'd0;
              gold_found_r <= 1'b0;
              count_r      <= 4'd0;
              target_r     <= target_s;
            end else if (tick) begin
              tick_cnt_r <= tick_cnt_r + 8'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler (default parameters).
module tb_hazard_scheduler;
  import hazard_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       game_active;
  logic [1:0] level;
  logic [8:0] warning_state;
  logic [8:0] fire_state;
  logic [8:0] gold_state;
  logic       round_done;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .start         (start),
    .game_active   (game_active),
    .level         (level),
    .warning_state (warning_state),
    .fire_state    (fire_state),
    .gold_state    (gold_state),
    .round_done    (round_done)
  );

  always #5 clk = ~clk;

  // one-cycle tick every 10 clocks, phase restarted by reset
  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        tcnt = 0;
        tick = 1'b0;
      end else begin
        tcnt = (tcnt == 9) ? 0 : tcnt + 1;
        tick = (tcnt == 9);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_active = 1'b0;
    start = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input string tag);
    int guard;
    guard = 0;
    while (dut.state_r != s && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, (guard < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // follow one full WARN/FIRE/GAP round and compare its shape
  task automatic observe_round(input int exp_pop, input int exp_warn);
    logic [8:0] m;
    int nt, rd, guard;
    bit bad, gbad;
    wait_state(ST_WARN, "warn_timeout");
    if (dut.state_r != ST_WARN) return;
    m = warning_state;
    chk("popcount", $countones(m), exp_pop);
    nt = 0; rd = 0; bad = 0; gbad = 0; guard = 0;
    while (dut.state_r == ST_WARN && guard < 1000) begin
      if (warning_state !== m || fire_state !== 9'd0) bad = 1;
`ifdef GOLD_SPAWN_EN
      if (!$onehot(gold_state) || (gold_state & m) != 9'd0) gbad = 1;
`else
      if (gold_state != 9'd0) gbad = 1;
`endif
      rd += int'(round_done);
      if (tick) nt++;
      @(negedge clk);
      guard++;
    end
    chk("warn_ticks", nt, exp_warn);
    chk("warn_mask", 32'(bad), 32'd0);
    chk("fire_entry", 32'(dut.state_r), 32'(ST_FIRE));
    nt = 0; bad = 0; guard = 0;
    while (dut.state_r == ST_FIRE && guard < 1000) begin
      if (fire_state !== m || warning_state !== 9'd0) bad = 1;
`ifdef GOLD_SPAWN_EN
      if (!$onehot(gold_state) || (gold_state & m) != 9'd0) gbad = 1;
`else
      if (gold_state != 9'd0) gbad = 1;
`endif
      rd += int'(round_done);
      if (tick) nt++;
      @(negedge clk);
      guard++;
    end
    chk("fire_ticks", nt, 3);
    chk("fire_mask", 32'(bad), 32'd0);
    chk("gap_entry", 32'(dut.state_r), 32'(ST_GAP));
    nt = 0; bad = 0; guard = 0;
    while (dut.state_r == ST_GAP && guard < 1000) begin
      if (fire_state !== 9'd0 || warning_state !== 9'd0) bad = 1;
      if (gold_state !== 9'd0) gbad = 1;
      rd += int'(round_done);
      if (tick) nt++;
      @(negedge clk);
      guard++;
    end
    chk("gap_ticks", nt, 2);
    chk("gap_zero", 32'(bad), 32'd0);
    chk("round_done_cnt", rd, 1);
    chk("gold_mask", 32'(gbad), 32'd0);
  endtask

  // signature of outputs and state over a fixed window after start
  task automatic run_capture(input bit pulse, output logic [31:0] sig);
    bit pulsed;
    do_reset();
    level = 2'd1;
    game_active = 1'b1;
    pulse_start();
    sig = 32'd0;
    pulsed = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      sig = (sig << 5) ^ (sig >> 27) ^
            {10'd0, dut.state_r, round_done, warning_state, fire_state};
      if (pulse && !pulsed && dut.state_r == ST_FIRE) begin
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        pulsed = 1;
      end
    end
    if (pulse) chk("fire_pulse_applied", 32'(pulsed), 32'd1);
  endtask

  initial begin
    logic [31:0] sig_a, sig_b;
    rst = 1'b1;
    start = 1'b0;
    game_active = 1'b0;
    level = 2'd0;
    repeat (3) cyc();
    chk("rst_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("rst_warn", 32'(warning_state), 32'd0);
    chk("rst_fire", 32'(fire_state), 32'd0);
    chk("rst_gold", 32'(gold_state), 32'd0);
    chk("rst_done", 32'(round_done), 32'd0);
    rst = 1'b0;

    // start without game_active is ignored
    pulse_start();
    chk("idle_no_game", 32'(dut.state_r), 32'(ST_IDLE));

    // level 0 rounds
    game_active = 1'b1;
    level = 2'd0;
    pulse_start();
    chk("start_pick", 32'(dut.state_r), 32'(ST_PICK));
    repeat (3) observe_round(1, 4);

    // asynchronous reset in the middle of FIRE
    wait_state(ST_FIRE, "fire_timeout");
    chk("fire_nonzero", (fire_state != 9'd0) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_fire", 32'(fire_state), 32'd0);
    chk("arst_warn", 32'(warning_state), 32'd0);
    chk("arst_gold", 32'(gold_state), 32'd0);
    chk("arst_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("arst_lfsr", 32'(dut.u_lfsr.state), 32'h0000ACE1);
    do_reset();

    // level 3: four boxes per round, one-tick warning
    game_active = 1'b1;
    level = 2'd3;
    pulse_start();
    repeat (200) observe_round(4, 1);

    // game_active dropped during WARN
    do_reset();
    level = 2'd0;
    game_active = 1'b1;
    pulse_start();
    wait_state(ST_WARN, "warn_timeout2");
    cyc();
    game_active = 1'b0;
    cyc();
    chk("drop_state", 32'(dut.state_r), 32'(ST_IDLE));
    chk("drop_masks", {5'd0, warning_state, fire_state, gold_state}, 32'd0);
    repeat (5) cyc();
    chk("drop_done", 32'(round_done), 32'd0);
    game_active = 1'b1;
    pulse_start();
    chk("restart_pick", 32'(dut.state_r), 32'(ST_PICK));
    observe_round(1, 4);

    // start during FIRE must not disturb the sequence
    run_capture(1'b0, sig_a);
    run_capture(1'b1, sig_b);
    chk("start_in_fire", sig_b, sig_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
